// File: rtl/reg_alu_seq_pkg.sv
// reg_alu_seq shared definitions: instruction encoding,
// FSM states and the control bundle driven to reg_alu.
package reg_alu_seq_pkg;

  localparam logic [1:0] CL_ALU  = 2'b00;
  localparam logic [1:0] CL_LDI  = 2'b01;
  localparam logic [1:0] CL_BR   = 2'b10;
  localparam logic [1:0] CL_HALT = 2'b11;

  localparam int CL_HI  = 15;
  localparam int CL_LO  = 14;
  localparam int OP_HI  = 13;
  localparam int OP_LO  = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 9;
  localparam int RB_HI  = 8;
  localparam int RB_LO  = 6;
  localparam int WD_HI  = 5;
  localparam int WD_LO  = 3;
  localparam int LW_HI  = 13;
  localparam int LW_LO  = 11;
  localparam int IMM_HI = 10;
  localparam int IMM_LO = 0;
  localparam int BR_JMP = 13;

  localparam logic [15:0] HALT_WORD = 16'hC000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef struct packed {
    logic        sel;
    logic        wr;
    logic [1:0]  op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  wa;
    logic [15:0] d_in;
  } ctrl_t;

endpackage

// File: rtl/reg_alu_seq_decode.sv
// Instruction decoder: one word plus held ALU operands in,
// reg_alu control bundle and branch/halt information out.
module seq_decode
  import reg_alu_seq_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic [15:0]   instr_i,
  input  logic [1:0]    hold_op_i,
  input  logic [2:0]    hold_ra_i,
  input  logic [2:0]    hold_rb_i,
  input  logic          cout_i,
  output ctrl_t         ctrl_o,
  output logic          is_alu_o,
  output logic          is_halt_o,
  output logic          taken_o,
  output logic [AW-1:0] target_o
);

  // Decode the class field; non-ALU words keep the held operands
  always_comb begin
    ctrl_o      = '0;
    ctrl_o.op   = hold_op_i;
    ctrl_o.ra   = hold_ra_i;
    ctrl_o.rb   = hold_rb_i;
    is_alu_o    = 1'b0;
    is_halt_o   = 1'b0;
    taken_o     = 1'b0;
    target_o    = instr_i[AW-1:0];
    unique case (instr_i[CL_HI:CL_LO])
      CL_ALU: begin
        is_alu_o  = 1'b1;
        ctrl_o.sel = 1'b1;
        ctrl_o.wr  = 1'b1;
        ctrl_o.op  = instr_i[OP_HI:OP_LO];
        ctrl_o.ra  = instr_i[RA_HI:RA_LO];
        ctrl_o.rb  = instr_i[RB_HI:RB_LO];
        ctrl_o.wa  = instr_i[WD_HI:WD_LO];
      end
      CL_LDI: begin
        ctrl_o.wr   = 1'b1;
        ctrl_o.wa   = instr_i[LW_HI:LW_LO];
        ctrl_o.d_in = {5'b0, instr_i[IMM_HI:IMM_LO]};
      end
      CL_BR: begin
        taken_o = instr_i[BR_JMP] | cout_i;
      end
      CL_HALT: begin
        is_halt_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/reg_alu_seq.sv
// Program sequencer for reg_alu: host-loaded program buffer,
// one instruction per clock, carry-conditional branching.
module reg_alu_seq
  import reg_alu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic          alu_sel,
  output logic          alu_wr,
  output logic [1:0]    alu_op,
  output logic [2:0]    alu_rd_addr_a,
  output logic [2:0]    alu_rd_addr_b,
  output logic [2:0]    alu_wr_addr,
  output logic [15:0]   alu_d_in,
  input  logic          alu_cout
);

  logic [15:0]   mem_q [DEPTH];
  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    hold_op_q;
  logic [2:0]    hold_ra_q, hold_rb_q;

  logic [15:0]   instr;
  ctrl_t         dec_c, out_c;
  logic          is_alu, is_halt, taken;
  logic [AW-1:0] target;
  logic          run;

  assign run   = (state_q == RUN);
  assign instr = mem_q[pc_q];

  seq_decode #(.AW(AW)) u_dec (
    .instr_i   (instr),
    .hold_op_i (hold_op_q),
    .hold_ra_i (hold_ra_q),
    .hold_rb_i (hold_rb_q),
    .cout_i    (alu_cout),
    .ctrl_o    (dec_c),
    .is_alu_o  (is_alu),
    .is_halt_o (is_halt),
    .taken_o   (taken),
    .target_o  (target)
  );

  // Program buffer: HALT-filled on reset, host writes only when not running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= HALT_WORD;
    end else if (prog_we && !run) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // State, pc and last-ALU operand hold registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      hold_op_q <= '0;
      hold_ra_q <= '0;
      hold_rb_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (run && is_alu) begin
        hold_op_q <= dec_c.op;
        hold_ra_q <= dec_c.ra;
        hold_rb_q <= dec_c.rb;
      end
    end
  end

  // Next state and next pc
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (is_halt) state_d = DONE;
        else if (taken) pc_d = target;
        else pc_d = pc_q + AW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Control bundle: decoded in RUN, quiet with held operands otherwise
  always_comb begin
    out_c = dec_c;
    if (!run) begin
      out_c      = '0;
      out_c.op   = hold_op_q;
      out_c.ra   = hold_ra_q;
      out_c.rb   = hold_rb_q;
    end
  end

  assign busy          = run;
  assign done          = (state_q == DONE);
  assign pc            = pc_q;
  assign alu_sel       = out_c.sel;
  assign alu_wr        = out_c.wr;
  assign alu_op        = out_c.op;
  assign alu_rd_addr_a = out_c.ra;
  assign alu_rd_addr_b = out_c.rb;
  assign alu_wr_addr   = out_c.wa;
  assign alu_d_in      = out_c.d_in;

endmodule
